chinpo_interrupt_controller: RTL and testbench

Collects external interrupt requests, latches them as pending, applies a software mask and fixed priority, and presents a single registered `Int` line to the CHINPO multicycle control unit. It sits directly upstream of the control unit. It holds `Int` until the control unit acknowledges by entering its Interrupt state, then supplies the handler vector and cause. It blocks further requests until the handler signals return.

---
 rtl/chinpo_pkg.sv | 33 +++
 rtl/chinpo_interrupt_controller_edge.sv | 54 +++++
 rtl/chinpo_interrupt_controller.sv | 143 ++++++++++++++
 tb/tb_chinpo_interrupt_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/chinpo_pkg.sv
// chinpo_pkg
// Shared definitions for the CHINPO interrupt controller:
//   - chinpo_state_e   : controller FSM state encoding
//   - CHINPO_VEC_BASE  : default handler address of source 0
//   - CHINPO_VEC_STRIDE: default spacing between per-source handlers
//   - prio_lowest()    : lowest-index-wins priority encoder over 8 request bits
package chinpo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } chinpo_state_e;

    localparam logic [15:0] CHINPO_VEC_BASE   = 16'h0F00;
    localparam logic [15:0] CHINPO_VEC_STRIDE = 16'h0010;

    // Returns the index of the lowest set bit; 0 when nothing is set.
    // Scanning from the top down lets the lowest index overwrite the others.
    function automatic logic [2:0] prio_lowest(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/chinpo_interrupt_controller_edge.sv
// chinpo_irq_edge
// Per-source request front end: optional 2-flop synchronizer, previous-value
// register and rising-edge detect. Defining CHINPO_IRQ_SYNC_EN inserts the
// synchronizer (reset to 0) ahead of the edge detector.
// Ports:
//   CLK   in  system clock, rising edge
//   Reset in  synchronous active-low reset
//   irq   in  raw request line
//   rise  out one-cycle indication that the (synchronized) line went 0->1
module chinpo_irq_edge
    import chinpo_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    input  logic irq,
    output logic rise
);

    logic irq_src_s;
    logic prev_r;

`ifdef CHINPO_IRQ_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer for asynchronous request sources.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= irq;
            sync2_r <= sync1_r;
        end
    end

    assign irq_src_s = sync2_r;
`else
    assign irq_src_s = irq;
`endif

    // Previous-value register; cleared by reset so a line already high at
    // release is seen as one edge.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= irq_src_s;
        end
    end

    assign rise = irq_src_s & ~prev_r;

endmodule

// File: rtl/chinpo_interrupt_controller.sv
// chinpo_interrupt_controller
// Latches interrupt edges as pending, gates them with a software mask, picks
// the lowest eligible index and holds a registered Int request until the
// control unit acknowledges; then reports in-service until handler return.
// Optional macro: CHINPO_IRQ_SYNC_EN (synchronize IrqIn before edge detect).
// Ports:
//   CLK, Reset (sync active-low)     clock / reset
//   IrqIn[NUM_SRC]                   raw request lines, rising edge = request
//   MaskWrite, MaskData[NUM_SRC]     mask load strobe and value (1 = enabled)
//   IntAck, IntReturn                acknowledge / handler-return pulses
//   Int                              registered request to the control unit
//   IntCause, IntVector              serviced source index and handler address
//   InService                        high from acknowledge until return
//   Pending[NUM_SRC]                 pending status bits
module chinpo_interrupt_controller
    import chinpo_pkg::*;
#(
    parameter int               NUM_SRC    = 4,
    parameter int               VEC_W      = 16,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(CHINPO_VEC_BASE),
    parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_W'(CHINPO_VEC_STRIDE),
    localparam int              CAUSE_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] IrqIn,
    input  logic               MaskWrite,
    input  logic [NUM_SRC-1:0] MaskData,
    input  logic               IntAck,
    input  logic               IntReturn,
    output logic               Int,
    output logic [CAUSE_W-1:0] IntCause,
    output logic [VEC_W-1:0]   IntVector,
    output logic               InService,
    output logic [NUM_SRC-1:0] Pending
);

    chinpo_state_e        state_r;
    chinpo_state_e        state_next_s;
    logic [CAUSE_W-1:0]   cause_r;
    logic [CAUSE_W-1:0]   cause_next_s;
    logic [CAUSE_W-1:0]   cause_pick_s;
    logic                 int_r;
    logic                 in_service_r;
    logic [NUM_SRC-1:0]   pending_r;
    logic [NUM_SRC-1:0]   mask_r;
    logic [NUM_SRC-1:0]   rise_s;
    logic [NUM_SRC-1:0]   eligible_s;
    logic [NUM_SRC-1:0]   clear_s;
    logic [7:0]           elig_pad_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
        chinpo_irq_edge u_edge (
            .CLK   (CLK),
            .Reset (Reset),
            .irq   (IrqIn[g]),
            .rise  (rise_s[g])
        );
    end

    assign eligible_s = pending_r & mask_r;

    // Widen eligibility to the encoder's fixed input width and pick a winner.
    always_comb begin
        elig_pad_s                = 8'd0;
        elig_pad_s[NUM_SRC-1:0]   = eligible_s;
        cause_pick_s              = CAUSE_W'(prio_lowest(elig_pad_s));
    end

    // Next-state logic: the cause is only re-chosen in IDLE, so it stays
    // frozen through REQUEST and SERVICE.
    always_comb begin
        state_next_s = state_r;
        cause_next_s = cause_r;
        clear_s      = '0;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_next_s = ST_REQUEST;
                    cause_next_s = cause_pick_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (IntAck) begin
                    state_next_s     = ST_SERVICE;
                    clear_s[cause_r] = 1'b1;
                end else begin
                    state_next_s = ST_REQUEST;
                end
            end
            ST_SERVICE: begin
                if (IntReturn) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SERVICE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs, decoded from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            cause_r      <= '0;
            int_r        <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cause_r      <= cause_next_s;
            int_r        <= (state_next_s == ST_REQUEST);
            in_service_r <= (state_next_s == ST_SERVICE);
        end
    end

    // Pending and mask registers; a new edge wins over the acknowledge clear.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pending_r <= '0;
            mask_r    <= '1;
        end else begin
            pending_r <= (pending_r & ~clear_s) | rise_s;
            if (MaskWrite) begin
                mask_r <= MaskData;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign Int       = int_r;
    assign InService = in_service_r;
    assign IntCause  = cause_r;
    assign Pending   = pending_r;
    assign IntVector = VEC_BASE + (VEC_W'(cause_r) * VEC_STRIDE);

endmodule

// File: tb/tb_chinpo_interrupt_controller.sv
module tb_chinpo_interrupt_controller;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [3:0]   IrqIn;
    logic         MaskWrite;
    logic [3:0]   MaskData;
    logic         IntAck;
    logic         IntReturn;
    logic         Int;
    logic [1:0]   IntCause;
    logic [15:0]  IntVector;
    logic         InService;
    logic [3:0]   Pending;

    chinpo_interrupt_controller dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .IrqIn     (IrqIn),
        .MaskWrite (MaskWrite),
        .MaskData  (MaskData),
        .IntAck    (IntAck),
        .IntReturn (IntReturn),
        .Int       (Int),
        .IntCause  (IntCause),
        .IntVector (IntVector),
        .InService (InService),
        .Pending   (Pending)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending set, mask, and whether a request or a
    // service is in progress, with the cause being served.
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [3:0] m_prev;
    bit [3:0] m_s1;
    bit [3:0] m_s2;
    bit       m_req;
    bit       m_svc;
    int       m_cause;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit [3:0] src;
        bit [3:0] rise;
        bit [3:0] np;
        bit       found;
        if (!Reset) begin
            m_pend = 4'd0; m_mask = 4'hF; m_prev = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0;
            m_req = 1'b0; m_svc = 1'b0; m_cause = 0;
        end else begin
`ifdef CHINPO_IRQ_SYNC_EN
            src  = m_s2;
            m_s2 = m_s1;
            m_s1 = IrqIn;
`else
            src  = IrqIn;
`endif
            rise   = src & ~m_prev;
            m_prev = src;
            np     = m_pend;
            if (m_req) begin
                if (IntAck) begin
                    m_req = 1'b0; m_svc = 1'b1; np[m_cause] = 1'b0;
                end
            end else if (m_svc) begin
                if (IntReturn) m_svc = 1'b0;
            end else begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[i] && m_mask[i]) begin
                        found = 1'b1; m_req = 1'b1; m_cause = i;
                    end
                end
            end
            m_pend = np | rise;
            if (MaskWrite) m_mask = MaskData;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Int"},       Int,       32'(m_req));
        check({tag, ".InService"}, InService, 32'(m_svc));
        check({tag, ".IntCause"},  IntCause,  32'(m_cause));
        check({tag, ".IntVector"}, IntVector, (32'h0F00 + 32'(m_cause) * 32'h10) & 32'hFFFF);
        check({tag, ".Pending"},   Pending,   32'(m_pend));
    endtask

    task automatic step(input string tag, input logic rst, input logic [3:0] irq,
                        input logic mw, input logic [3:0] md, input logic ack, input logic ret);
        Reset = rst; IrqIn = irq; MaskWrite = mw; MaskData = md; IntAck = ack; IntReturn = ret;
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b0; IrqIn = 4'd0; MaskWrite = 1'b0; MaskData = 4'd0; IntAck = 1'b0; IntReturn = 1'b0;
        m_pend = 4'd0; m_mask = 4'hF; m_prev = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0;
        m_req = 1'b0; m_svc = 1'b0; m_cause = 0;

        // Reset state
        step("rst0", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("rst1", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("rst_int", Int, 32'd0);
        check("rst_vec", IntVector, 32'h0F00);
        step("idle", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Single source, two-cycle latency, vector and acknowledge
        step("irq2_k",  1'b1, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0);
        check("irq2_noint_yet", Int, 32'd0);
        step("irq2_k1", 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
        check("irq2_int", Int, 32'd1);
        check("irq2_cause", IntCause, 32'd2);
        check("irq2_vec", IntVector, 32'h0F20);
        step("irq2_ack", 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ack_int", Int, 32'd0);
        check("ack_insvc", InService, 32'd1);
        check("ack_pend2", Pending[2], 32'd0);
        step("irq2_ret", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Simultaneous sources: lowest index first, next one after return
        step("dual_k",   1'b1, 4'b1010, 1'b0, 4'd0, 1'b0, 1'b0);
        step("dual_k1",  1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
        check("dual_cause1", IntCause, 32'd1);
        step("dual_ack", 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        step("dual_ret", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("dual_ret_int", Int, 32'd0);
        step("dual_r1",  1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("dual_int3", Int, 32'd1);
        check("dual_cause3", IntCause, 32'd3);
        step("dual_ack3", 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        step("dual_ret3", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Masked source accumulates pending without requesting
        step("mask_w",  1'b1, 4'd0,    1'b1, 4'b1110, 1'b0, 1'b0);
        step("mask_i0", 1'b1, 4'b0001, 1'b0, 4'd0,    1'b0, 1'b0);
        step("mask_h0", 1'b1, 4'b0000, 1'b0, 4'd0,    1'b0, 1'b0);
        step("mask_h1", 1'b1, 4'b0000, 1'b0, 4'd0,    1'b0, 1'b0);
        check("mask_pend0", Pending[0], 32'd1);
        check("mask_noint", Int, 32'd0);
        step("mask_en", 1'b1, 4'd0, 1'b1, 4'b1111, 1'b0, 1'b0);
        step("mask_rq", 1'b1, 4'd0, 1'b0, 4'd0,    1'b0, 1'b0);
        check("mask_int", Int, 32'd1);
        check("mask_cause0", IntCause, 32'd0);

        // Held request: no ack for 10 cycles, edges and stray returns
        for (int i = 0; i < 10; i++) begin
            step("hold", 1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 4'd0, 1'b0, 1'(i % 3 == 0));
            check("hold_int", Int, 32'd1);
            check("hold_cause", IntCause, 32'd0);
        end
        step("pre_ack", 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);
        // New edge on the acknowledged source in the ack cycle
        step("ack_edge", 1'b1, 4'b0001, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ack_edge_pend0", Pending[0], 32'd1);
        check("ack_edge_insvc", InService, 32'd1);

        // Reset mid-service with a line held high through reset
        step("mid_rst", 1'b0, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
        check("mid_rst_insvc", InService, 32'd0);
        check("mid_rst_pend", Pending, 32'd0);
        check("mid_rst_vec", IntVector, 32'h0F00);
        step("rel_k",  1'b1, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
        step("rel_k1", 1'b1, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
        check("rel_int", Int, 32'd1);
        check("rel_cause", IntCause, 32'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            step("rand",
                 1'($urandom_range(0, 79) != 0),
                 4'($urandom),
                 1'($urandom_range(0, 7) == 0),
                 4'($urandom),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
